// File: rtl/prog_mem_loadable_pkg.sv
// Shared definitions for the loadable program memory: FSM encodings,
// output-select encodings and the NOP opcode used to build NOP_INSTR.
package prog_mem_loadable_pkg;

  localparam int INSTR_W_DEF = 28;
  localparam logic [3:0] OP_NOP = 4'h0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_NOP = 2'd0,
    SEL_RAM = 2'd1,
    SEL_DEF = 2'd2
  } out_sel_t;

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM, read-first, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module prog_mem_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 28,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/prog_mem_loadable.sv
// Loadable program memory: RUN serves 1-cycle fetches, LOAD accepts an image
// over a valid/ready stream. Optional oChecksum port under PROG_MEM_CHECKSUM_EN.
module prog_mem_loadable
  import prog_mem_loadable_pkg::*;
#(
  parameter int                 INSTR_W       = INSTR_W_DEF,
  parameter int                 ADDR_W        = 16,
  parameter int                 DEPTH         = 256,
  parameter logic [INSTR_W-1:0] NOP_INSTR     = {OP_NOP, {(INSTR_W-4){1'b0}}},
  parameter logic [INSTR_W-1:0] DEFAULT_INSTR = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  iAddress,
  output logic [INSTR_W-1:0] oInstruction,
  output logic               oBusy,
  input  logic               iLoadStart,
  input  logic [INSTR_W-1:0] iLoadData,
  input  logic               iLoadValid,
  input  logic               iLoadLast,
  output logic               oLoadReady,
  output logic [ADDR_W:0]    oLoadCount,
  output logic               oLoadError,
`ifdef PROG_MEM_CHECKSUM_EN
  output logic [INSTR_W-1:0] oChecksum,
`endif
  output logic [1:0]         dbg_state
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  out_sel_t           sel_q;
  logic [ADDR_W:0]    ptr_q;
  logic               err_q;
  logic               start_ok;
  logic               xfer;
  logic               ptr_full;
  logic               wr_en;
  logic               addr_in_range;
  logic [RAM_AW-1:0]  ram_addr;
  logic [INSTR_W-1:0] ram_rdata;

  // Handshake: a beat transfers on any cycle where iLoadValid && oLoadReady
  // are both high at the rising edge; oLoadReady depends only on the state.
  // iLoadStart has priority, so a beat coinciding with it is discarded.
  assign start_ok      = iLoadStart && (state_q != ST_FINISH);
  assign xfer          = iLoadValid && oLoadReady && !iLoadStart;
  assign ptr_full      = (ptr_q == DEPTH_P);
  assign wr_en         = xfer && !ptr_full && !Reset;
  assign addr_in_range = ({1'b0, iAddress} < DEPTH_P);

  // The single RAM port follows the write pointer while loading.
  assign ram_addr = (state_q == ST_LOAD) ? ptr_q[RAM_AW-1:0]
                                         : iAddress[RAM_AW-1:0];

  prog_mem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (Clock),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (iLoadData),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    oLoadReady = 1'b0;
    oBusy      = 1'b1;
    unique case (state_q)
      ST_RUN: begin
        oBusy = 1'b0;
        if (iLoadStart) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        oLoadReady = 1'b1;
        if (xfer && iLoadLast) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      sel_q   <= SEL_NOP;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        ptr_q <= '0;
        err_q <= 1'b0;
      end else if (xfer) begin
        if (!ptr_full) ptr_q <= ptr_q + (ADDR_W+1)'(1);
        else           err_q <= 1'b1;
      end
      // The RAM read register is unreset, so the output source is tracked
      // separately and the NOP/default words never touch the RAM path.
      if (state_q == ST_RUN && !iLoadStart) begin
        sel_q <= addr_in_range ? SEL_RAM : SEL_DEF;
      end else begin
        sel_q <= SEL_NOP;
      end
    end
  end

  always_comb begin
    unique case (sel_q)
      SEL_RAM: oInstruction = ram_rdata;
      SEL_DEF: oInstruction = DEFAULT_INSTR;
      default: oInstruction = NOP_INSTR;
    endcase
  end

  // Writes and count advance together, so the pointer doubles as the count.
  assign oLoadCount = ptr_q;
  assign oLoadError = err_q;
  assign dbg_state  = state_q;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [INSTR_W-1:0] csum_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (wr_en) begin
      csum_q <= csum_q + iLoadData;
    end
  end

  assign oChecksum = csum_q;
`endif

endmodule
